count_arbiter: RTL and testbench

COUNT_ARBITER -- requirements
Module: count_arbiter

---
 rtl/count_arb_pkg.sv | 13 +
 rtl/count_arbiter_run_counter.sv | 23 ++
 rtl/count_arbiter.sv | 128 ++++++++++++
 tb/tb_count_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_arb_pkg.sv
// Shared types and default sizing for the count arbiter.
package count_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned CW_DEFAULT   = 3;

endpackage

// File: rtl/count_arbiter_run_counter.sv
// Shared run counter: synchronous clear/enable up-counter with an all-ones flag.
module run_counter #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] Q,
    output logic          y
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            Q <= '0;
        end else if (en) begin
            Q <= Q + CW'(1);
        end
    end

    assign y = &Q;

endmodule

// File: rtl/count_arbiter.sv
// Round-robin arbiter that lends one shared counter to a requester for a bounded run.
module count_arbiter
    import count_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned CW   = CW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    grant,
    output logic [CW-1:0]      Q,
    output logic               y,
    output logic               busy,
    output logic               done,
    output logic               abort
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q;
    logic [PW-1:0]     last_ptr_q;
    logic [CW-1:0]     limit_q;
    logic [NREQ-1:0]   grant_q;
    logic              busy_q;
    logic              done_q;
    logic              abort_q;

    logic [PW:0]       sel;
    logic [PW-1:0]     pick;
    logic              pick_valid;
    logic [NREQ-1:0]   pick_onehot;
    logic              owner_req;
    logic              cnt_clr;
    logic              cnt_en;

    // Returns {valid, index} of the first requester after last, wrapping.
    function automatic logic [PW:0] rr_select(input logic [NREQ-1:0] r,
                                               input logic [PW-1:0]   last);
        logic [PW:0]   res;
        logic [PW-1:0] cand;
        int            idx;
        res = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx  = (int'(last) + k) % int'(NREQ);
            cand = idx[PW-1:0];
            if (!res[PW] && r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    always_comb begin
        sel         = rr_select(req, last_ptr_q);
        pick        = sel[PW-1:0];
        pick_valid  = sel[PW];
        pick_onehot = '0;
        pick_onehot[pick] = 1'b1;
        // last_ptr_q names the current owner for the whole run.
        owner_req   = req[last_ptr_q];
        cnt_clr     = (state_q != StRun);
        cnt_en      = (state_q == StRun) && owner_req && (Q != limit_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            last_ptr_q <= PW'(NREQ - 1);
            limit_q    <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q    <= StRun;
                        grant_q    <= pick_onehot;
                        limit_q    <= len[pick*CW +: CW];
                        last_ptr_q <= pick;
                        busy_q     <= 1'b1;
                    end
                end
                StRun: begin
                    if (!owner_req) begin
                        state_q <= StDone;
                        grant_q <= '0;
                        done_q  <= 1'b1;
                        abort_q <= 1'b1;
                    end else if (Q == limit_q) begin
                        state_q <= StDone;
                        grant_q <= '0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    abort_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    run_counter #(
        .CW (CW)
    ) u_run_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .Q     (Q),
        .y     (y)
    );

    assign grant = grant_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign abort = abort_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter: vector table, directed corner cases, random vs model.
module tb_count_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 3;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]   grant;
    logic [CW-1:0]     Q;
    logic              y;
    logic              busy;
    logic              done;
    logic              abort;

    int checks = 0;
    int errors = 0;

    count_arbiter #(
        .NREQ (NREQ),
        .CW   (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .grant (grant),
        .Q     (Q),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .abort (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [11:0] ln;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Packed view: {grant, Q, y, busy, done, abort}.
    function automatic logic [10:0] pk(input logic [3:0] g, input logic [2:0] q, input logic yy,
                                       input logic b, input logic d, input logic a);
        return {g, q, yy, b, d, a};
    endfunction

    function automatic logic [10:0] outs();
        return {grant, Q, y, busy, done, abort};
    endfunction

    task automatic add(input logic rst, input logic [3:0] rq, input logic [11:0] ln,
                       input logic [10:0] exp);
        vec_t v;
        v.rst = rst;
        v.rq  = rq;
        v.ln  = ln;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic apply(input logic rst, input logic [3:0] rq, input logic [11:0] ln);
        reset = rst;
        req   = rq;
        len   = ln;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {grant,Q,y,busy,done,abort}=%b required %b", name, got, exp);
        end
    endtask

    // Reference model state: plain integers following the behavioural rules.
    int  m_phase;   // 0 = waiting, 1 = counter lent out, 2 = closing cycle
    int  m_owner;
    int  m_cnt;
    int  m_lim;
    int  m_last;
    bit  m_done;
    bit  m_abort;

    task automatic model_step(input logic rst, input logic [3:0] rq, input logic [11:0] ln);
        int c;
        if (rst) begin
            m_phase = 0; m_owner = -1; m_cnt = 0; m_lim = 0; m_last = NREQ - 1;
            m_done = 0; m_abort = 0;
        end else if (m_phase == 0) begin
            m_owner = -1;
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (m_owner < 0 && ((rq >> c) & 4'd1) != 0) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_lim   = int'((ln >> (m_owner * CW)) & 12'd7);
                m_cnt   = 0;
                m_last  = m_owner;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (((rq >> m_owner) & 4'd1) == 0) begin
                m_phase = 2; m_done = 1; m_abort = 1;
            end else if (m_cnt == m_lim) begin
                m_phase = 2; m_done = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            m_phase = 0; m_cnt = 0; m_done = 0; m_abort = 0; m_owner = -1;
        end
    endtask

    function automatic logic [10:0] model_out();
        logic [3:0] g;
        logic [2:0] q;
        g = (m_phase == 1) ? 4'(1 << m_owner) : 4'd0;
        q = 3'(m_cnt);
        return pk(g, q, m_cnt == 7, m_phase != 0, m_done, m_abort);
    endfunction

    initial begin
        logic [3:0]  rq;
        logic [11:0] ln;
        logic        rs;

        reset = 1'b1;
        req   = '0;
        len   = '0;

        // Single requester, limit 3.
        add(1, 4'b0000, 12'd0, pk(4'b0000, 3'd0, 0, 0, 0, 0));
        for (int k = 0; k <= 3; k++)
            add(0, 4'b0001, 12'd3, pk(4'b0001, 3'(k), 0, 1, 0, 0));
        add(0, 4'b0001, 12'd3, pk(4'b0000, 3'd3, 0, 1, 1, 0));
        add(0, 4'b0000, 12'd3, pk(4'b0000, 3'd0, 0, 0, 0, 0));
        // All requesting with zero limits: rotating 3-cycle grants.
        add(1, 4'b0000, 12'd0, pk(4'b0000, 3'd0, 0, 0, 0, 0));
        for (int g = 0; g < 5; g++) begin
            add(0, 4'b1111, 12'd0, pk(4'(1 << (g % 4)), 3'd0, 0, 1, 0, 0));
            add(0, 4'b1111, 12'd0, pk(4'b0000, 3'd0, 0, 1, 1, 0));
            add(0, 4'b1111, 12'd0, pk(4'b0000, 3'd0, 0, 0, 0, 0));
        end
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].rq, tbl[i].ln);
            check($sformatf("table[%0d]", i), outs(), tbl[i].exp);
        end

        // Full-range run on requester 2: no wrap, y only at all-ones.
        apply(1, 4'b0000, 12'd0);
        for (int k = 0; k <= 7; k++) begin
            apply(0, 4'b0100, 12'(7 << 6));
            check($sformatf("fullrun_q%0d", k), outs(), pk(4'b0100, 3'(k), k == 7, 1, 0, 0));
        end
        apply(0, 4'b0100, 12'(7 << 6));
        check("fullrun_done", outs(), pk(4'b0000, 3'd7, 1, 1, 1, 0));
        apply(0, 4'b0000, 12'(7 << 6));
        check("fullrun_idle", outs(), pk(4'b0000, 3'd0, 0, 0, 0, 0));

        // Owner drops request at Q=2: abort with Q frozen.
        apply(1, 4'b0000, 12'd0);
        for (int k = 0; k <= 2; k++) apply(0, 4'b0100, 12'(5 << 6));
        check("abort_q2", outs(), pk(4'b0100, 3'd2, 0, 1, 0, 0));
        apply(0, 4'b0000, 12'(5 << 6));
        check("abort_done", outs(), pk(4'b0000, 3'd2, 0, 1, 1, 1));
        apply(0, 4'b0000, 12'(5 << 6));
        check("abort_idle", outs(), pk(4'b0000, 3'd0, 0, 0, 0, 0));

        // Reset mid-run at Q=4, then pointer must be back at requester 3.
        apply(1, 4'b0000, 12'd0);
        for (int k = 0; k <= 4; k++) apply(0, 4'b0001, 12'd7);
        check("midrun_q4", outs(), pk(4'b0001, 3'd4, 0, 1, 0, 0));
        apply(1, 4'b0001, 12'd7);
        check("midrun_reset", outs(), pk(4'b0000, 3'd0, 0, 0, 0, 0));
        apply(0, 4'b0000, 12'd7);
        check("midrun_nodone1", outs(), pk(4'b0000, 3'd0, 0, 0, 0, 0));
        apply(0, 4'b0000, 12'd7);
        check("midrun_nodone2", outs(), pk(4'b0000, 3'd0, 0, 0, 0, 0));
        apply(0, 4'b1001, 12'd0);
        check("midrun_ptr", outs(), pk(4'b0001, 3'd0, 0, 1, 0, 0));
        apply(1, 4'b0000, 12'd0);
        apply(0, 4'b1000, 12'd0);
        check("midrun_req3", outs(), pk(4'b1000, 3'd0, 0, 1, 0, 0));

        // len changes mid-run do not move the latched limit.
        apply(1, 4'b0000, 12'd0);
        apply(0, 4'b0001, 12'd2);
        apply(0, 4'b0001, 12'd2);
        check("lenchg_q1", outs(), pk(4'b0001, 3'd1, 0, 1, 0, 0));
        apply(0, 4'b0001, 12'd6);
        check("lenchg_q2", outs(), pk(4'b0001, 3'd2, 0, 1, 0, 0));
        apply(0, 4'b0001, 12'd6);
        check("lenchg_done", outs(), pk(4'b0000, 3'd2, 0, 1, 1, 0));

        // Randomized traffic against the reference model.
        rq = 4'b1111;
        ln = 12'($urandom);
        apply(1, rq, ln);
        model_step(1, rq, ln);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0) rq = 4'($urandom);
            if ($urandom_range(0, 3) == 0) ln = 12'($urandom);
            rs = ($urandom_range(0, 99) == 0);
            apply(rs, rq, ln);
            model_step(rs, rq, ln);
            check($sformatf("random[%0d]", cyc), outs(), model_out());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
